// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU operation codes, executor states and op classification helpers
//
// Purpose: single definition of the 5-bit ALUControl encoding shared by the
// decoder and the execution unit, plus the executor FSM state type.
// Ports: none (package).

package alu_pkg;

   typedef enum logic [4:0] {
      OP_ADD   = 5'b00000,
      OP_SUB   = 5'b00001,
      OP_AND   = 5'b00010,
      OP_OR    = 5'b00011,
      OP_XOR   = 5'b00100,
      OP_SLT   = 5'b00101,
      OP_SLL   = 5'b00110,
      OP_SRL   = 5'b00111,
      OP_SRA   = 5'b01000,
      OP_SLLI  = 5'b01001,
      OP_SRAI  = 5'b01010,
      OP_ADDI  = 5'b01100,
      OP_SLTI  = 5'b01101,
      OP_SLTIU = 5'b01110,
      OP_XORI  = 5'b01111,
      OP_SRLI  = 5'b10000,
      OP_ORI   = 5'b10001,
      OP_ANDI  = 5'b10010,
      OP_JALR  = 5'b10011,
      OP_SLTU  = 5'b10100
   } alu_op_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } exec_state_e;

   function automatic logic is_shift(alu_op_e op);
      case (op)
         OP_SLL, OP_SLLI, OP_SRL, OP_SRLI, OP_SRA, OP_SRAI: return 1'b1;
         default:                                           return 1'b0;
      endcase
   endfunction

   function automatic logic is_right_shift(alu_op_e op);
      case (op)
         OP_SRL, OP_SRLI, OP_SRA, OP_SRAI: return 1'b1;
         default:                          return 1'b0;
      endcase
   endfunction

   function automatic logic is_arith_shift(alu_op_e op);
      case (op)
         OP_SRA, OP_SRAI: return 1'b1;
         default:         return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/alu_shift_unit.sv
// rtl/alu_shift_unit.sv - iterative one-bit-per-cycle shifter
//
// Purpose: holds the operand being shifted and the remaining shift count.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clear        drop any shift in progress (count forced to 0)
//   load         capture din/shamt/dir/arith
//   din, shamt   operand and number of single-bit steps to perform
//   dir, arith   1 = right shift; arith selects sign fill for right shifts
//   step         advance one bit while busy
//   busy, last   count nonzero / count equals one (final step this cycle)
//   dout_next    operand after one more step (final result when last)

module alu_shift_unit #(
   parameter int XLEN    = 32,
   parameter int SHAMT_W = $clog2(XLEN)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clear,
   input  logic               load,
   input  logic [XLEN-1:0]    din,
   input  logic [SHAMT_W-1:0] shamt,
   input  logic               dir,
   input  logic               arith,
   input  logic               step,
   output logic               busy,
   output logic               last,
   output logic [XLEN-1:0]    dout_next
);

   logic [XLEN-1:0]    data;
   logic [SHAMT_W-1:0] cnt;
   logic               dir_q;
   logic               arith_q;

   assign busy = (cnt != '0);
   assign last = (cnt == SHAMT_W'(1));

   // The sign bit never changes during an arithmetic right shift, so
   // refilling from the current MSB is the same as refilling from a[XLEN-1].
   assign dout_next = dir_q ? {arith_q & data[XLEN-1], data[XLEN-1:1]}
                            : {data[XLEN-2:0], 1'b0};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data    <= '0;
         cnt     <= '0;
         dir_q   <= 1'b0;
         arith_q <= 1'b0;
      end else if (clear) begin
         cnt <= '0;
      end else if (load) begin
         data    <= din;
         cnt     <= shamt;
         dir_q   <= dir;
         arith_q <= arith;
      end else if (step && busy) begin
         data <= dout_next;
         cnt  <= cnt - SHAMT_W'(1);
      end
   end

endmodule

// File: rtl/alu_iter_exec.sv
// rtl/alu_iter_exec.sv - ALU executor: single-cycle ops, iterative shifts, valid/ready handshake
//
// Purpose: consumes the decoder's ALUControl code with operands, produces a
// registered result. Shifts with a nonzero amount take one cycle per bit.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid, in_ready   operation handshake (in_ready only in IDLE, not during flush)
//   alu_ctrl, a, b       op code and operands, sampled only at accept
//   flush                abort any in-flight op; wins over accept and out_ready
//   out_valid, out_ready result handshake (out_valid held until out_ready)
//   result, zero         registered result and (result == 0)
//   illegal              registered: op code was unassigned

module alu_iter_exec
   import alu_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int SHAMT_W = $clog2(XLEN)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [4:0]      alu_ctrl,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            zero,
   output logic            illegal
);

   exec_state_e        state, state_nxt;
   alu_op_e            op;
   logic [SHAMT_W-1:0] shamt;
   logic               accept;
   logic               start_shift;
   logic [XLEN-1:0]    alu_res;
   logic               alu_ill;
   logic               shift_busy;
   logic               shift_last;
   logic [XLEN-1:0]    shift_next;

   assign op          = alu_op_e'(alu_ctrl);
   assign shamt       = b[SHAMT_W-1:0];
   assign in_ready    = (state == IDLE) && !flush;
   assign out_valid   = (state == DONE);
   assign accept      = in_valid && in_ready;
   // A zero-amount shift is just a copy of a, so it rides the single-cycle path.
   assign start_shift = accept && is_shift(op) && (shamt != '0);

   always_comb begin
      alu_res = '0;
      alu_ill = 1'b0;
      case (op)
         OP_ADD, OP_ADDI:   alu_res = a + b;
         OP_SUB:            alu_res = a - b;
         OP_AND, OP_ANDI:   alu_res = a & b;
         OP_OR, OP_ORI:     alu_res = a | b;
         OP_XOR, OP_XORI:   alu_res = a ^ b;
         OP_SLT, OP_SLTI:   alu_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
         OP_SLTU, OP_SLTIU: alu_res = {{(XLEN-1){1'b0}}, a < b};
         OP_JALR:           alu_res = (a + b) & {{(XLEN-1){1'b1}}, 1'b0};
         OP_SLL, OP_SLLI, OP_SRL, OP_SRLI, OP_SRA, OP_SRAI:
                            alu_res = a;
         default:           alu_ill = 1'b1;
      endcase
   end

   alu_shift_unit #(
      .XLEN    (XLEN),
      .SHAMT_W (SHAMT_W)
   ) u_shift (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (flush),
      .load      (start_shift),
      .din       (a),
      .shamt     (shamt),
      .dir       (is_right_shift(op)),
      .arith     (is_arith_shift(op)),
      .step      ((state == SHIFT) && shift_busy),
      .busy      (shift_busy),
      .last      (shift_last),
      .dout_next (shift_next)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept)     state_nxt = start_shift ? SHIFT : DONE;
         SHIFT:   if (shift_last) state_nxt = DONE;
         DONE:    if (out_ready)  state_nxt = IDLE;
         default:                 state_nxt = IDLE;
      endcase
      if (flush) state_nxt = IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // On flush the outputs keep their previous value; only the state is dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result  <= '0;
         zero    <= 1'b0;
         illegal <= 1'b0;
      end else if (!flush) begin
         if (accept && !start_shift) begin
            result  <= alu_res;
            zero    <= (alu_res == '0);
            illegal <= alu_ill;
         end else if ((state == SHIFT) && shift_last) begin
            result  <= shift_next;
            zero    <= (shift_next == '0);
            illegal <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_alu_iter_exec.sv
// tb/tb_alu_iter_exec.sv - scoreboard bench for alu_iter_exec with randomized and directed ops

module tb_alu_iter_exec;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  alu_ctrl;
   logic [31:0] a;
   logic [31:0] b;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        zero;
   logic        illegal;

   typedef struct {
      logic [31:0] res;
      logic        zero;
      logic        ill;
      int          lat;
      int          acc;
   } exp_t;

   exp_t sbq[$];
   exp_t mon_e;
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   bit   rand_rdy = 0;
   bit   seen     = 0;

   alu_iter_exec #(.XLEN(32), .SHAMT_W(5)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .alu_ctrl  (alu_ctrl),
      .a         (a),
      .b         (b),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .zero      (zero),
      .illegal   (illegal)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   initial begin
      #600000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference behaviour straight from the op table: plain arithmetic on raw codes.
   function automatic void ref_model(input logic [4:0] c, input logic [31:0] av, input logic [31:0] bv,
                                     output logic [31:0] r, output logic ill, output int lat);
      int sh;
      bit shift_op;
      sh       = int'(bv[4:0]);
      ill      = 1'b0;
      shift_op = 1'b0;
      r        = 32'd0;
      case (c)
         5'd0, 5'd12:  r = av + bv;
         5'd1:         r = av - bv;
         5'd2, 5'd18:  r = av & bv;
         5'd3, 5'd17:  r = av | bv;
         5'd4, 5'd15:  r = av ^ bv;
         5'd5, 5'd13:  r = ($signed(av) < $signed(bv)) ? 32'd1 : 32'd0;
         5'd14, 5'd20: r = (av < bv) ? 32'd1 : 32'd0;
         5'd6, 5'd9:   begin r = av << sh; shift_op = 1'b1; end
         5'd7, 5'd16:  begin r = av >> sh; shift_op = 1'b1; end
         5'd8, 5'd10:  begin r = 32'($signed(av) >>> sh); shift_op = 1'b1; end
         5'd19:        r = (av + bv) & 32'hFFFF_FFFE;
         default:      begin r = 32'd0; ill = 1'b1; end
      endcase
      lat = (shift_op && sh != 0) ? sh + 1 : 1;
   endfunction

   // Monitor: checks each result the first cycle it is presented.
   always @(negedge clk) begin
      if (!rst_n || !out_valid) begin
         seen = 0;
      end else if (!seen) begin
         seen = 1;
         if (sbq.size() == 0) begin
            chk("unexpected_out_valid", {31'd0, out_valid}, 32'd0);
         end else begin
            mon_e = sbq.pop_front();
            chk("result",  result, mon_e.res);
            chk("zero",    {31'd0, zero}, {31'd0, mon_e.zero});
            chk("illegal", {31'd0, illegal}, {31'd0, mon_e.ill});
            chk("latency", cyc - mon_e.acc, mon_e.lat);
         end
      end
   end

   always @(negedge clk) begin
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
   end

   task automatic issue(input logic [4:0] c, input logic [31:0] av, input logic [31:0] bv, input bit push);
      exp_t e;
      int   n;
      @(negedge clk);
      alu_ctrl = c;
      a        = av;
      b        = bv;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         chk("accept_timeout", {31'd0, in_ready}, 32'd1);
         in_valid = 1'b0;
         return;
      end
      if (push) begin
         ref_model(c, av, bv, e.res, e.ill, e.lat);
         e.zero = (e.res == 32'd0);
         e.acc  = cyc;
         sbq.push_back(e);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      alu_ctrl = 5'($urandom);
      a        = $urandom;
      b        = $urandom;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((sbq.size() != 0 || !in_ready) && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("drain_pending", sbq.size(), 32'd0);
   endtask

   initial begin
      logic [31:0] ra, rb;
      int n;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      alu_ctrl  = 5'd0;
      a         = 32'd0;
      b         = 32'd0;
      flush     = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
      chk("reset_result", result, 32'd0);
      chk("reset_zero", {31'd0, zero}, 32'd0);
      chk("reset_illegal", {31'd0, illegal}, 32'd0);
      chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed single ops
      issue(5'd0,  32'd7,         32'd5,  1);
      issue(5'd1,  32'h1234,      32'h1234, 1);
      issue(5'd5,  32'hFFFF_FFFF, 32'd1,  1);
      issue(5'd20, 32'hFFFF_FFFF, 32'd1,  1);
      issue(5'd8,  32'h8000_0000, 32'd4,  1);
      issue(5'd6,  32'hDEAD_BEEF, 32'h40, 1);
      issue(5'd7,  32'hCAFE_F00D, 32'd31, 1);
      issue(5'd31, 32'h1111_2222, 32'h3, 1);
      issue(5'd11, 32'h5555_0000, 32'h7, 1);
      issue(5'd19, 32'h1001,      32'd4,  1);
      issue(5'd10, 32'h9000_0001, 32'd1,  1);
      issue(5'd16, 32'h8000_0000, 32'd1,  1);
      drain();

      // Randomized ops with random result backpressure
      rand_rdy = 1;
      for (int i = 0; i < 150; i++) begin
         ra = $urandom;
         rb = $urandom;
         if ($urandom_range(0, 3) == 0) ra = {32{ra[0]}};
         if ($urandom_range(0, 3) == 0) rb = ra;
         issue(5'($urandom_range(0, 31)), ra, rb, 1);
      end
      rand_rdy = 0;
      @(negedge clk);
      out_ready = 1'b1;
      drain();

      // Backpressure: result held stable for 10 cycles
      @(negedge clk);
      out_ready = 1'b0;
      issue(5'd1, 32'h0000_0100, 32'd1, 1);
      @(negedge clk);
      n = 0;
      while (!out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      for (int i = 0; i < 10; i++) begin
         chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
         chk("bp_result", result, 32'h0000_00FF);
         chk("bp_zero", {31'd0, zero}, 32'd0);
         chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
         if (i < 9) @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("release_in_ready", {31'd0, in_ready}, 32'd1);
      chk("release_out_valid", {31'd0, out_valid}, 32'd0);

      // Flush on the third SHIFT cycle of SLL by 20
      issue(5'd6, 32'h0000_0001, 32'd20, 0);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      flush = 1'b1;
      #1;
      chk("flush_in_ready_low", {31'd0, in_ready}, 32'd0);
      @(posedge clk);
      #1;
      flush = 1'b0;
      @(negedge clk);
      chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
      chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
      repeat (25) begin
         @(negedge clk);
         chk("flush_no_valid", {31'd0, out_valid}, 32'd0);
      end
      issue(5'd0, 32'h0000_0FF0, 32'h0000_0010, 1);
      drain();

      // Asynchronous reset in the middle of a shift
      issue(5'd31, 32'h1234_5678, 32'd9, 1);
      drain();
      issue(5'd8, 32'h8000_0000, 32'd20, 0);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("arst_result", result, 32'd0);
      chk("arst_zero", {31'd0, zero}, 32'd0);
      chk("arst_illegal", {31'd0, illegal}, 32'd0);
      chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (25) begin
         @(negedge clk);
         chk("arst_no_valid", {31'd0, out_valid}, 32'd0);
      end
      issue(5'd12, 32'hFFFF_FFFF, 32'd2, 1);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
